cr_fifo_rr_drain: RTL and testbench
===================================

Name: cr_fifo_rr_drain

Overview:
- Round-robin read scheduler that drains N_PORTS independent register/RAM FIFOs into a single registered output stream with valid/ready flow control.
- Sits downstream of a bank of cr_fifo_wrap2 instances: consumes their empty/rdata, drives their ren.
- Supports packet-atomic grants (hold until EOP beat) or beat-limited bursts, so one shared datapath can be time-shared fairly between requesters.

Parameters:
- N_PORTS, 4, number of source FIFOs (2..16).
- N_DATA_BITS, 64, FIFO word width; bit N_DATA_BITS-1 is EOP when PKT_MODE=1.
- PKT_MODE, 1, 1 = grant held until EOP beat popped; 0 = burst-limited grants.
- BURST_LIM, 8, max beats per grant when PKT_MODE=0 (1..255); ignored when PKT_MODE=1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- fifo_empty  input  N_PORTS  per-FIFO empty flag.
- fifo_rdata  input  N_PORTS*N_DATA_BITS  per-FIFO head word, valid combinationally while !empty; port i at [i*N_DATA_BITS +: N_DATA_BITS].
- fifo_ren  output  N_PORTS  per-FIFO pop strobe, combinational, at most one bit set.
- out_valid  output  1  output word valid.
- out_data  output  N_DATA_BITS  output word.
- out_port  output  clog2(N_PORTS)  source index of out_data.
- out_ready  input  1  downstream accept.
- idle  output  1  state IDLE, all fifo_empty set, out_valid low.
- stat_beats  output  N_PORTS*32  per-port popped-beat counters (see Optional Feature).

Behaviour:
- Reset values: out_valid=0, out_data=0, out_port=0, fifo_ren=0, state=IDLE, gnt=0, last_gnt=N_PORTS-1 (port 0 wins first), beat_cnt=0, stat_beats=0.
- FSM IDLE:
  - If any !fifo_empty, select the first non-empty port searching last_gnt+1, last_gnt+2, ... with wrap.
  - Register it into gnt, set last_gnt=gnt, clear beat_cnt, go XFER.
  - No pop occurs in IDLE, so arbitration costs 1 cycle.
- FSM XFER:
  - pop = !fifo_empty[gnt] & (!out_valid | out_ready).
  - fifo_ren[gnt] = pop; all other ren bits 0.
- Output register:
  - On pop, load out_data=fifo_rdata[gnt], out_port=gnt, out_valid=1.
  - Else if out_ready, set out_valid=0.
  - Latency pop -> out_valid is 1 cycle; sustained throughput is 1 beat/cycle inside a grant.
- Release with PKT_MODE=1:
  - Leave XFER to IDLE on the cycle a popped word has EOP=1.
  - An empty FIFO mid-packet holds the grant; no rotation until EOP.
- Release with PKT_MODE=0:
  - Leave on the pop where beat_cnt==BURST_LIM-1.
  - Also leave on any XFER cycle with fifo_empty[gnt]=1 and no pop.
- beat_cnt is 8 bits: increments on pop, clears on entering XFER.
- Backpressure: out_valid & !out_ready holds out_data/out_port stable and suppresses all ren.
- Reset asserted mid-grant: immediate return to reset values; the partially popped packet is the source's responsibility.
- The scheduler never pops a FIFO with fifo_empty=1, so it cannot cause underflow.

Optional Feature:
- Macro CR_FIFO_RR_DRAIN_STATS_EN.
- Defined: stat_beats[i] increments on each fifo_ren[i], saturating at 32'hFFFF_FFFF, and clears on reset.
- Undefined: stat_beats is tied to 0 and no counter flops are built.

Test Plan:
- PKT_MODE=1, ports 0 and 2 each hold a 3-beat packet, out_ready=1:
  - Output is port0 beats 0,1,2 (EOP on the 3rd), one idle cycle, then port2 x3.
  - out_port sequence 0,0,0,2,2,2.
- PKT_MODE=0, BURST_LIM=4, port1 holds 10 words and port3 holds 2, out_ready=1:
  - Order: port1 x4, port3 x2, port1 x4, port1 x2.
- out_ready held low for 5 cycles after the first beat:
  - out_data is stable, fifo_ren stays 0, and no word is lost or duplicated when out_ready returns.
- PKT_MODE=1, port0 goes empty after 2 non-EOP beats for 6 cycles while port1 is non-empty:
  - Grant is held on port0, port1 is not popped, and the packet completes when port0 refills.
- Reset pulsed mid-packet:
  - All outputs return to reset values on the same cycle.
  - After release, port0 wins first arbitration.
- With CR_FIFO_RR_DRAIN_STATS_EN defined, after the first scenario:
  - stat_beats[0]=3 and stat_beats[2]=3, others 0.
  - With the macro undefined, stat_beats reads 0.

Source files
------------

// File: rtl/cr_fifo_rr_drain_if.sv
// Purpose : bundles the FIFO-bank side (empty/rdata/ren) and the output stream side
//           (valid/data/port/ready) of the round-robin drain, plus idle and beat statistics.
// Latency : none, signal container only.
// Backpressure: out_ready from the consumer; the scheduler stalls all pops while out_valid & !out_ready.
// Modports: master = scheduler (drives fifo_ren/out_*/idle/stat_beats),
//           slave  = surrounding logic (drives fifo_empty/fifo_rdata/out_ready).
interface cr_fifo_rr_drain_if #(
  parameter int N_PORTS     = 4,
  parameter int N_DATA_BITS = 64
);
  localparam int PW = $clog2(N_PORTS);

  logic [N_PORTS-1:0]             fifo_empty;
  logic [N_PORTS*N_DATA_BITS-1:0] fifo_rdata;
  logic [N_PORTS-1:0]             fifo_ren;
  logic                           out_valid;
  logic [N_DATA_BITS-1:0]         out_data;
  logic [PW-1:0]                  out_port;
  logic                           out_ready;
  logic                           idle;
  logic [N_PORTS*32-1:0]          stat_beats;

  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output fifo_ren, out_valid, out_data, out_port, idle, stat_beats
  );

  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  fifo_ren, out_valid, out_data, out_port, idle, stat_beats
  );
endinterface

// File: rtl/cr_fifo_rr_drain.sv
// Purpose : round-robin drain of N_PORTS FIFOs into one registered valid/ready stream,
//           packet-atomic grants (PKT_MODE=1, EOP = top data bit) or BURST_LIM-beat grants.
// Latency : 1 cycle arbitration in IDLE, then pop -> out_valid 1 cycle, 1 beat/cycle in a grant.
// Backpressure: out_valid & !out_ready holds out_data/out_port and suppresses every fifo_ren.
// Ports   : clk, rst_n (async, active-low); bus (master modport of cr_fifo_rr_drain_if).
// Option  : define CR_FIFO_RR_DRAIN_STATS_EN to build saturating per-port popped-beat
//           counters on stat_beats; otherwise stat_beats is tied to zero.
module cr_fifo_rr_drain #(
  parameter int N_PORTS     = 4,
  parameter int N_DATA_BITS = 64,
  parameter int PKT_MODE    = 1,
  parameter int BURST_LIM   = 8
) (
  input logic                clk,
  input logic                rst_n,
  cr_fifo_rr_drain_if.master bus
);
  localparam int PW = $clog2(N_PORTS);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PW-1:0]          r_gnt;
  logic [PW-1:0]          r_last_gnt;
  logic [PW-1:0]          w_sel;
  logic [7:0]             r_beat_cnt;
  logic                   r_out_valid;
  logic [N_DATA_BITS-1:0] r_out_data;
  logic [PW-1:0]          r_out_port;
  logic [N_DATA_BITS-1:0] w_head;
  logic [N_PORTS-1:0]     w_ren;
  logic                   w_any;
  logic                   w_pop;
  logic                   w_release;
  logic                   w_load;

  assign w_any  = ~&bus.fifo_empty;
  assign w_head = bus.fifo_rdata[r_gnt*N_DATA_BITS +: N_DATA_BITS];
  assign w_pop  = (r_state == S_XFER) & ~bus.fifo_empty[r_gnt] & (~r_out_valid | bus.out_ready);

  // Rotating priority search starting after last_gnt. Offsets are walked from the
  // farthest to the nearest so the nearest non-empty port is the final assignment.
  always_comb begin
    w_sel = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      int idx;
      idx = int'(r_last_gnt) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!bus.fifo_empty[idx]) w_sel = PW'(idx);
    end
  end

  // Grant release: EOP beat popped, or burst exhausted / source ran dry.
  always_comb begin
    if (PKT_MODE != 0) begin
      w_release = w_pop & w_head[N_DATA_BITS-1];
    end else begin
      w_release = (w_pop & (r_beat_cnt == 8'(BURST_LIM - 1))) | bus.fifo_empty[r_gnt];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ren       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        w_ren[r_gnt] = w_pop;
        if (w_release) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt      <= '0;
      r_last_gnt <= PW'(N_PORTS - 1);
      r_beat_cnt <= '0;
    end else if (w_load) begin
      r_gnt      <= w_sel;
      r_last_gnt <= w_sel;
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= r_beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_port  <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_head;
      r_out_port  <= r_gnt;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef CR_FIFO_RR_DRAIN_STATS_EN
  logic [N_PORTS-1:0][31:0] r_stat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (w_ren[i] && (r_stat[i] != 32'hFFFF_FFFF)) r_stat[i] <= r_stat[i] + 32'd1;
      end
    end
  end

  assign bus.stat_beats = r_stat;
`else
  assign bus.stat_beats = '0;
`endif

  assign bus.fifo_ren  = w_ren;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_port  = r_out_port;
  assign bus.idle      = (r_state == S_IDLE) & ~w_any & ~r_out_valid;
endmodule

// File: tb/tb_cr_fifo_rr_drain.sv
`timescale 1ns/1ps
module tb_cr_fifo_rr_drain;
  localparam int NP = 4;
  localparam int NB = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cr_fifo_rr_drain_if #(.N_PORTS(NP), .N_DATA_BITS(NB)) pk_if ();
  cr_fifo_rr_drain_if #(.N_PORTS(NP), .N_DATA_BITS(NB)) bs_if ();

  cr_fifo_rr_drain #(.N_PORTS(NP), .N_DATA_BITS(NB), .PKT_MODE(1), .BURST_LIM(8)) u_pk (
    .clk(clk), .rst_n(rst_n), .bus(pk_if.master)
  );
  cr_fifo_rr_drain #(.N_PORTS(NP), .N_DATA_BITS(NB), .PKT_MODE(0), .BURST_LIM(4)) u_bs (
    .clk(clk), .rst_n(rst_n), .bus(bs_if.master)
  );

  int total = 0;
  int bad   = 0;

  // Source FIFO models: index 0 feeds u_pk, index 1 feeds u_bs.
  logic [63:0] mem [2][NP][32];
  int          rp  [2][NP];
  int          wp  [2][NP];
  int          n_acc [2];
  int          acc_port [2][64];
  logic [63:0] acc_data [2][64];
  int          acc_cyc  [2][64];
  int          cyc = 0;

  function automatic logic [63:0] pw(input int port, input int beat, input bit eop);
    logic [62:0] body;
    body = 63'(port * 256 + beat);
    return {eop, body};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      pk_if.fifo_empty[i]          = (rp[0][i] == wp[0][i]);
      pk_if.fifo_rdata[i*NB +: NB] = mem[0][i][rp[0][i] & 31];
      bs_if.fifo_empty[i]          = (rp[1][i] == wp[1][i]);
      bs_if.fifo_rdata[i*NB +: NB] = mem[1][i][rp[1][i] & 31];
    end
  endtask

  task automatic push(input int d, input int p, input logic [63:0] w);
    mem[d][p][wp[d][p] & 31] = w;
    wp[d][p]++;
    refresh();
  endtask

  // One clock: record accepted beats and pop strobes at the falling edge, then
  // retire the pops in the source models just after the rising edge.
  task automatic tick();
    logic [NP-1:0] rk;
    logic [NP-1:0] rb;
    @(negedge clk);
    cyc++;
    if (pk_if.out_valid && pk_if.out_ready && n_acc[0] < 64) begin
      acc_port[0][n_acc[0]] = int'(pk_if.out_port);
      acc_data[0][n_acc[0]] = pk_if.out_data;
      acc_cyc[0][n_acc[0]]  = cyc;
      n_acc[0]++;
    end
    if (bs_if.out_valid && bs_if.out_ready && n_acc[1] < 64) begin
      acc_port[1][n_acc[1]] = int'(bs_if.out_port);
      acc_data[1][n_acc[1]] = bs_if.out_data;
      acc_cyc[1][n_acc[1]]  = cyc;
      n_acc[1]++;
    end
    rk = pk_if.fifo_ren;
    rb = bs_if.fifo_ren;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (rk[i] && rp[0][i] != wp[0][i]) rp[0][i]++;
      if (rb[i] && rp[1][i] != wp[1][i]) rp[1][i]++;
    end
    refresh();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NP; i++) begin
        rp[d][i] = 0;
        wp[d][i] = 0;
      end
      n_acc[d] = 0;
    end
    refresh();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e1_port [6];
    int e1_beat [6];
    int e2_port [12];
    int e2_seq  [12];
    logic [31:0] s_exp [NP];

    e1_port = '{0, 0, 0, 2, 2, 2};
    e1_beat = '{0, 1, 2, 0, 1, 2};
    e2_port = '{1, 1, 1, 1, 3, 3, 1, 1, 1, 1, 1, 1};
    e2_seq  = '{0, 1, 2, 3, 0, 1, 4, 5, 6, 7, 8, 9};
`ifdef CR_FIFO_RR_DRAIN_STATS_EN
    s_exp = '{32'd3, 32'd0, 32'd3, 32'd0};
`else
    s_exp = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NP; i++)
        for (int j = 0; j < 32; j++) mem[d][i][j] = '0;
    pk_if.out_ready = 1'b1;
    bs_if.out_ready = 1'b1;

    // Reset state with every source empty.
    do_reset();
    chk("rst_out_valid", pk_if.out_valid, 0);
    chk("rst_out_data",  pk_if.out_data,  0);
    chk("rst_out_port",  pk_if.out_port,  0);
    chk("rst_fifo_ren",  pk_if.fifo_ren,  0);
    chk("rst_idle",      pk_if.idle,      1);
    chk("rst_stat",      pk_if.stat_beats, 0);

    // Packet mode: ports 0 and 2 each hold a 3-beat packet.
    for (int b = 0; b < 3; b++) push(0, 0, pw(0, b, b == 2));
    for (int b = 0; b < 3; b++) push(0, 2, pw(2, b, b == 2));
    rst_n = 1'b1;
    repeat (12) tick();
    chk("s1_count", n_acc[0], 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("s1_port%0d", k), acc_port[0][k], e1_port[k]);
      chk($sformatf("s1_data%0d", k), acc_data[0][k], pw(e1_port[k], e1_beat[k], e1_beat[k] == 2));
    end
    chk("s1_gap", acc_cyc[0][3] - acc_cyc[0][2], 2);
    chk("s1_idle", pk_if.idle, 1);
    for (int i = 0; i < NP; i++)
      chk($sformatf("s1_stat%0d", i), pk_if.stat_beats[i*32 +: 32], s_exp[i]);

    // Burst mode (limit 4): port1 holds 10 words, port3 holds 2.
    do_reset();
    for (int s = 0; s < 10; s++) push(1, 1, pw(1, s, 0));
    for (int s = 0; s < 2; s++)  push(1, 3, pw(3, s, 0));
    rst_n = 1'b1;
    repeat (30) tick();
    chk("s2_count", n_acc[1], 12);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("s2_port%0d", k), acc_port[1][k], e2_port[k]);
      chk($sformatf("s2_data%0d", k), acc_data[1][k], pw(e2_port[k], e2_seq[k], 0));
    end

    // Backpressure: out_ready low for 5 cycles once the first beat is presented.
    do_reset();
    for (int b = 0; b < 4; b++) push(0, 1, pw(1, b, b == 3));
    rst_n = 1'b1;
    repeat (2) tick();
    chk("s3_first_valid", pk_if.out_valid, 1);
    pk_if.out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("s3_hold_data", pk_if.out_data, pw(1, 0, 0));
      chk("s3_hold_ren",  pk_if.fifo_ren, 0);
    end
    chk("s3_nopop", rp[0][1], 1);
    pk_if.out_ready = 1'b1;
    repeat (10) tick();
    chk("s3_count", n_acc[0], 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("s3_data%0d", k), acc_data[0][k], pw(1, k, k == 3));

    // Packet hold: port0 runs dry mid-packet while port1 has a packet waiting.
    do_reset();
    push(0, 0, pw(0, 0, 0));
    push(0, 0, pw(0, 1, 0));
    for (int b = 0; b < 3; b++) push(0, 1, pw(1, b, b == 2));
    rst_n = 1'b1;
    repeat (4) tick();
    repeat (6) begin
      tick();
      chk("s4_hold_ren", pk_if.fifo_ren, 0);
    end
    chk("s4_p1_untouched", rp[0][1], 0);
    push(0, 0, pw(0, 2, 1));
    repeat (12) tick();
    chk("s4_count", n_acc[0], 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("s4_data%0d", k), acc_data[0][k], pw(k / 3, k % 3, (k % 3) == 2));

    // Reset mid-packet: outputs clear without a clock edge, port0 wins afterwards.
    do_reset();
    for (int b = 0; b < 5; b++) push(0, 0, pw(0, b, b == 4));
    push(0, 2, pw(2, 0, 1));
    rst_n = 1'b1;
    repeat (3) tick();
    chk("s5_pre_valid", pk_if.out_valid, 1);
    chk("s5_pre_data",  pk_if.out_data, pw(0, 1, 0));
    rst_n = 1'b0;
    #1;
    chk("s5_rst_valid", pk_if.out_valid, 0);
    chk("s5_rst_data",  pk_if.out_data, 0);
    chk("s5_rst_port",  pk_if.out_port, 0);
    chk("s5_rst_ren",   pk_if.fifo_ren, 0);
    chk("s5_rst_stat",  pk_if.stat_beats, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_acc[0] = 0;
    repeat (4) tick();
    chk("s5_after_count_ge1", n_acc[0] >= 1, 1);
    chk("s5_first_port", acc_port[0][0], 0);
    chk("s5_first_data", acc_data[0][0], pw(0, 2, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
